spi_slave_sync: RTL and testbench

- Synchronous SPI responder (slave). It runs entirely on the system clock and oversamples the master's SCLK/SS/MOSI lines.
- It is the counterpart to the team's SPI master and replaces the SCLK-clocked slave wherever the slave side must hand words to clk-domain logic.
- Mode 0 (CPOL=0, CPHA=0), MSB first, active-low SS.
- Exposes valid/ready streams for transmit and receive words.

---
 rtl/spi_slave_sync_if.sv | 31 +++
 rtl/spi_slave_sync.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave_sync.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_sync_if.sv
// Signal bundle between an SPI slave block and its surroundings: the
// SPI pins plus the clk-domain tx/rx valid/ready streams.
interface spi_slave_sync_if #(
    parameter int width = 8
);
    logic             SCLK;
    logic             SS;
    logic             MOSI;
    logic             MISO;
    logic [width-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [width-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_overrun;
    logic             tx_underrun;
    logic             busy;

    // Seen from the slave block
    modport slave (
        input  SCLK, SS, MOSI, tx_data, tx_valid, rx_ready,
        output MISO, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy
    );

    // Seen from the SPI master / stream user side
    modport master (
        output SCLK, SS, MOSI, tx_data, tx_valid, rx_ready,
        input  MISO, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave running entirely on clk. SCLK/SS/MOSI are oversampled
// through 2-FF synchronisers; words are exchanged with clk-domain logic
// over valid/ready streams. MSB first, active-low SS.
module spi_slave_sync #(
    parameter int               width     = 8,
    parameter logic [width-1:0] IDLE_WORD = {width{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_sync_if.slave  bus
);
    localparam int              CNT_W    = $clog2(width + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Pin index: 0 = SCLK, 1 = SS, 2 = MOSI
    logic [2:0]       w_pin;
    logic [2:0]       w_sync;
    logic             r_sclk_hist;
    logic             r_ss_hist;
    logic             w_sclk_rise;
    logic             w_sclk_fall;
    logic             w_ss_rise;
    logic             w_ss_fall;
    logic             w_mosi;

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_word_done;
    logic [width-1:0] r_rx_shift;
    logic [width-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_overrun;
    logic             r_busy;

    logic [width-1:0] r_tx_shift;
    logic [width-1:0] r_hold;
    logic             r_hold_full;
    logic             r_tx_underrun;

    logic             w_tx_write;
    logic             w_tx_load;
    logic [width-1:0] w_rx_word;

    assign w_pin = {bus.MOSI, bus.SS, bus.SCLK};

    // Two-stage synchronisers; the SS chain idles high so reset never looks like a select
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            localparam logic RST_VAL = (gi == 1);
            logic r_s1;
            logic r_s2;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1 <= RST_VAL;
                    r_s2 <= RST_VAL;
                end else begin
                    r_s1 <= w_pin[gi];
                    r_s2 <= r_s1;
                end
            end
            assign w_sync[gi] = r_s2;
        end
    endgenerate

    // History stage for SCLK/SS edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_hist <= 1'b0;
            r_ss_hist   <= 1'b1;
        end else begin
            r_sclk_hist <= w_sync[0];
            r_ss_hist   <= w_sync[1];
        end
    end

    assign w_sclk_rise = w_sync[0] & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sync[0] & r_sclk_hist;
    assign w_ss_fall   = ~w_sync[1] & r_ss_hist;
    assign w_ss_rise   = w_sync[1] & ~r_ss_hist;
    assign w_mosi      = w_sync[2];

    // Load strobes: word start on select, or the falling edge after a completed
    // word while still selected (SS rising always takes priority over SCLK)
    always_comb begin
        w_tx_write = bus.tx_valid & ~r_hold_full;
        w_tx_load  = ((r_state == ST_IDLE) & w_ss_fall) |
                     ((r_state == ST_SHIFT) & ~w_ss_rise & w_sclk_fall & r_word_done);
        w_rx_word  = {r_rx_shift[width-2:0], w_mosi};
    end

    // Transmit path: holding register, shift register and underrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift    <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_tx_load) begin
                if (r_hold_full) begin
                    r_tx_shift <= r_hold;
                end else begin
                    r_tx_shift    <= IDLE_WORD;
                    r_tx_underrun <= 1'b1;
                end
            end else if ((r_state == ST_SHIFT) && !w_ss_rise && w_sclk_fall) begin
                r_tx_shift <= r_tx_shift << 1;
            end
            // A write only happens into an empty holding register, so a
            // simultaneous load never sees the freshly written word
            if (w_tx_write) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end else if (w_tx_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    // Framing FSM and receive path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_word_done  <= 1'b0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            // Consumer handshake; a word completing this cycle overrides it below
            if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state     <= ST_SHIFT;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_ss_rise) begin
                        // Partial word is dropped without touching rx_data
                        r_state     <= ST_IDLE;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_word;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_rx_data   <= w_rx_word;
                            r_rx_valid  <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                            if (r_rx_valid && !bus.rx_ready) begin
                                r_rx_overrun <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end else if (w_sclk_fall) begin
                        r_word_done <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.MISO        = (r_state == ST_SHIFT) & r_tx_shift[width-1];
    assign bus.tx_ready    = ~r_hold_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_overrun  = r_rx_overrun;
    assign bus.tx_underrun = r_tx_underrun;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: bit-level SPI master at SCLK = clk/8, a tx
// feeder that writes queued words whenever tx_ready is high, and a
// word-level reference model (FIFO of tx words, pending-rx flag).
module tb_spi_slave_sync;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_sync_if #(.width(W)) bus();

    spi_slave_sync #(.width(W), .IDLE_WORD(8'hFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_under  = 0;
    int n_over   = 0;
    int n_rxev   = 0;
    logic prev_rxv = 1'b0;

    logic [7:0] supply_q[$];
    logic [7:0] model_q[$];
    logic [7:0] mosi_words[4];
    logic [7:0] miso_words[4];
    logic       rxv_trace[4];
    logic       model_pend = 1'b0;
    logic [7:0] model_rx   = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clk cycle: sample just after the edge, run the tx feeder, count pulses
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.tx_valid) begin
            bus.tx_valid = 1'b0;
            void'(supply_q.pop_front());
        end
        if (!bus.tx_valid && supply_q.size() > 0 && bus.tx_ready) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = supply_q[0];
        end
        if (bus.tx_underrun) n_under++;
        if (bus.rx_overrun)  n_over++;
        if (bus.rx_valid && !prev_rxv) n_rxev++;
        prev_rxv = bus.rx_valid;
    endtask

    task automatic give(input logic [7:0] w);
        supply_q.push_back(w);
        model_q.push_back(w);
    endtask

    task automatic rx_clear(input string name);
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        model_pend = 1'b0;
        chk({name, " rx_valid cleared"}, bus.rx_valid, 1'b0);
    endtask

    // Bit-level mode-0 master. cut>0 stops after that many bits; the final bit of
    // a full transfer drops SCLK and raises SS together.
    task automatic xfer(input int nw, input int cut, input bit leave_selected);
        int total;
        total   = (cut > 0) ? cut : nw * 8;
        n_under = 0;
        n_over  = 0;
        n_rxev  = 0;
        bus.MOSI = mosi_words[0][7];
        bus.SS   = 1'b0;
        repeat (4) step();
        chk("busy during transfer", bus.busy, 1'b1);
        for (int b = 0; b < total; b++) begin
            miso_words[b / 8][7 - (b % 8)] = bus.MISO;
            bus.SCLK = 1'b1;
            for (int s = 0; s < 4; s++) begin
                step();
                rxv_trace[s] = bus.rx_valid;
            end
            bus.SCLK = 1'b0;
            if (b == total - 1 && cut == 0) begin
                bus.SS = 1'b1;
            end else if (b + 1 < total) begin
                bus.MOSI = mosi_words[(b + 1) / 8][7 - ((b + 1) % 8)];
            end
            if (!(leave_selected && b == total - 1)) repeat (4) step();
        end
        if (cut > 0 && !leave_selected) begin
            bus.SS = 1'b1;
            repeat (4) step();
        end
    endtask

    // Word-level expectations for a complete transfer with rx_ready held low
    task automatic check_xfer(input string name, input int nw);
        int exp_under;
        int exp_over;
        int exp_ev;
        logic [7:0] exp_tx;
        exp_under = 0;
        exp_over  = 0;
        exp_ev    = 0;
        for (int k = 0; k < nw; k++) begin
            if (model_q.size() > 0) begin
                exp_tx = model_q.pop_front();
            end else begin
                exp_tx = 8'hFF;
                exp_under++;
            end
            chk($sformatf("%s miso word%0d", name, k), miso_words[k], exp_tx);
            if (model_pend) exp_over++;
            else exp_ev++;
            model_pend = 1'b1;
            model_rx   = mosi_words[k];
        end
        chk({name, " rx_data"}, bus.rx_data, model_rx);
        chk({name, " rx_valid"}, bus.rx_valid, model_pend);
        chk({name, " tx_underrun count"}, n_under, exp_under);
        chk({name, " rx_overrun count"}, n_over, exp_over);
        chk({name, " rx_valid events"}, n_rxev, exp_ev);
        chk({name, " busy after"}, bus.busy, 1'b0);
        chk({name, " MISO idle"}, bus.MISO, 1'b0);
        $display("xfer %s: words=%0d mosi0=%02h miso0=%02h rx_data=%02h underruns=%0d overruns=%0d",
                 name, nw, mosi_words[0], miso_words[0], bus.rx_data, n_under, n_over);
    endtask

    task automatic check_abort(input string name);
        int exp_under;
        exp_under = 0;
        if (model_q.size() > 0) void'(model_q.pop_front());
        else exp_under = 1;
        chk({name, " rx_data unchanged"}, bus.rx_data, model_rx);
        chk({name, " rx_valid unchanged"}, bus.rx_valid, model_pend);
        chk({name, " tx_underrun count"}, n_under, exp_under);
        chk({name, " rx_overrun count"}, n_over, 0);
        chk({name, " busy after"}, bus.busy, 1'b0);
        $display("abort %s: rx_data=%02h rx_valid=%0b underruns=%0d",
                 name, bus.rx_data, bus.rx_valid, n_under);
    endtask

    initial begin
        int nw;
        int ns;
        bus.SCLK     = 1'b0;
        bus.SS       = 1'b1;
        bus.MOSI     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;

        // Reset and idle state
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset MISO", bus.MISO, 1'b0);
        chk("reset tx_ready", bus.tx_ready, 1'b1);
        chk("reset rx_valid", bus.rx_valid, 1'b0);
        chk("reset rx_data", bus.rx_data, 8'h00);
        chk("reset busy", bus.busy, 1'b0);
        $display("reset: idle outputs sampled");

        // Single word with a buffered tx word
        give(8'hA5);
        repeat (4) step();
        mosi_words[0] = 8'h3C;
        xfer(1, 0, 1'b0);
        check_xfer("single", 1);
        chk("rx_valid 2 clk after last rise", rxv_trace[1], 1'b0);
        chk("rx_valid 3 clk after last rise", rxv_trace[2], 1'b1);
        rx_clear("single");

        // Nothing buffered: idle word goes out, one underrun
        repeat (4) step();
        mosi_words[0] = 8'h00;
        xfer(1, 0, 1'b0);
        check_xfer("underrun", 1);
        rx_clear("underrun");

        // Back-to-back words under one select, rx never accepted
        give(8'h11);
        give(8'h22);
        repeat (4) step();
        mosi_words[0] = 8'h01;
        mosi_words[1] = 8'h02;
        xfer(2, 0, 1'b0);
        check_xfer("back2back", 2);
        rx_clear("back2back");

        // Select dropped after 5 bits, then a clean word
        repeat (4) step();
        mosi_words[0] = 8'hE7;
        xfer(1, 5, 1'b0);
        check_abort("ss_abort");
        repeat (4) step();
        mosi_words[0] = 8'h5A;
        xfer(1, 0, 1'b0);
        check_xfer("after_abort", 1);

        // Reset in the middle of a word (rx_valid left pending beforehand)
        mosi_words[0] = 8'h81;
        xfer(1, 4, 1'b1);
        rst      = 1'b1;
        bus.SS   = 1'b1;
        bus.SCLK = 1'b0;
        step();
        chk("midrst MISO", bus.MISO, 1'b0);
        chk("midrst tx_ready", bus.tx_ready, 1'b1);
        chk("midrst rx_valid", bus.rx_valid, 1'b0);
        chk("midrst rx_data", bus.rx_data, 8'h00);
        chk("midrst busy", bus.busy, 1'b0);
        chk("midrst rx_overrun", bus.rx_overrun, 1'b0);
        chk("midrst tx_underrun", bus.tx_underrun, 1'b0);
        $display("midrst: outputs sampled during reset");
        rst = 1'b0;
        model_q.delete();
        model_pend = 1'b0;
        model_rx   = 8'h00;
        give(8'h96);
        repeat (4) step();
        mosi_words[0] = 8'hC3;
        xfer(1, 0, 1'b0);
        check_xfer("after_rst", 1);
        rx_clear("after_rst");

        // Randomised transfers against the word-level model
        for (int it = 0; it < 6; it++) begin
            nw = $urandom_range(1, 3);
            ns = $urandom_range(0, nw);
            for (int k = 0; k < ns; k++) give(8'($urandom));
            for (int k = 0; k < nw; k++) mosi_words[k] = 8'($urandom);
            repeat (4) step();
            xfer(nw, 0, 1'b0);
            check_xfer($sformatf("rand%0d", it), nw);
            rx_clear($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
